// File: rtl/bcd2bin_test_sweep.sv
// Stimulus/checker harness for an N-digit BCD-to-binary converter: generates DUT reset,
// drives operands (decimal sweep or LFSR random), checks every result, reports sticky pass/fail.
module bcd2bin_test_sweep #(
    parameter int          DIGITS       = 2,
    parameter int          BIN_WIDTH    = 7,
    parameter int          MODE         = 0,
    parameter int          NUM_TESTS    = 64,
    parameter logic [31:0] SEED         = 32'hACE1_2468,
    parameter int          TIMEOUT      = 256,
    parameter int          RESET_CYCLES = 8
) (
    input  logic                  tb_clk,
    input  logic                  tb_rst_n,
    output logic                  tb_pass,
    output logic                  tb_fail,
    input  logic                  tb_prog_done,
    input  logic [31:0]           tb_verbosity,
    input  logic [31:0]           tb_cycle_cnt,
    output logic                  clk,
    output logic                  reset,
    output logic                  start,
    output logic [4*DIGITS-1:0]   bcd,
    input  logic                  ready,
    input  logic                  done_tick,
    input  logic [BIN_WIDTH-1:0]  bin
);

    localparam int              BW       = 4 * DIGITS;
    localparam logic [31:0]     TOTAL    = (MODE == 0) ? 32'(10 ** DIGITS) : 32'(NUM_TESTS);
    localparam int              RCW      = $clog2(RESET_CYCLES + 2) + 1;
    localparam logic [RCW-1:0]  RST_LAST = RCW'(RESET_CYCLES + 1);

    typedef enum logic [2:0] {
        S_RST,
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                 state;
    logic [RCW-1:0]         rst_cnt;
    logic [31:0]            test_cnt;
    logic [31:0]            wd;
    logic [31:0]            lfsr;
    logic [BW-1:0]          sweep_bcd;
    logic [BIN_WIDTH-1:0]   sweep_bin;
    logic [BIN_WIDTH-1:0]   expected;

    logic [BW-1:0]          lfsr_bcd;
    logic [BIN_WIDTH-1:0]   lfsr_exp;
    logic [BW-1:0]          op_bcd;
    logic [BIN_WIDTH-1:0]   op_exp;
    logic [31:0]            lfsr_next;
    logic [31:0]            wd_next;

    // Message-formatting inputs only matter to the simulation wrapper.
    logic unused_ok;
    assign unused_ok = ^{tb_verbosity, tb_cycle_cnt};

    assign clk = tb_clk;

    function automatic logic [BW-1:0] bcd_inc(input logic [BW-1:0] v);
        logic [BW-1:0] r;
        logic          carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (r[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [3:0] nib_to_digit(input logic [3:0] n);
        return (n >= 4'd10) ? n - 4'd10 : n;
    endfunction

    // NOTE: every variable driven in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        lfsr_bcd = '0;
        lfsr_exp = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            lfsr_bcd[4*i +: 4] = nib_to_digit(lfsr[4*i +: 4]);
            lfsr_exp = lfsr_exp * BIN_WIDTH'(10) + BIN_WIDTH'(nib_to_digit(lfsr[4*i +: 4]));
        end
    end

    assign op_bcd    = (MODE == 0) ? sweep_bcd : lfsr_bcd;
    assign op_exp    = (MODE == 0) ? sweep_bin : lfsr_exp;
    assign lfsr_next = {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};
    assign wd_next   = wd + 32'd1;

    // NOTE: sequential state uses non-blocking assignments only; both resets restore identical values.
    always_ff @(posedge tb_clk or negedge tb_rst_n) begin
        if (!tb_rst_n) begin
            state     <= S_RST;
            rst_cnt   <= '0;
            test_cnt  <= '0;
            wd        <= '0;
            lfsr      <= SEED;
            sweep_bcd <= '0;
            sweep_bin <= '0;
            expected  <= '0;
            reset     <= 1'b1;
            start     <= 1'b0;
            bcd       <= '0;
            tb_pass   <= 1'b0;
            tb_fail   <= 1'b0;
        end else if (!tb_prog_done) begin
            state     <= S_RST;
            rst_cnt   <= '0;
            test_cnt  <= '0;
            wd        <= '0;
            lfsr      <= SEED;
            sweep_bcd <= '0;
            sweep_bin <= '0;
            expected  <= '0;
            reset     <= 1'b1;
            start     <= 1'b0;
            bcd       <= '0;
            tb_pass   <= 1'b0;
            tb_fail   <= 1'b0;
        end else begin
            start <= 1'b0;
            // A result outside WAIT (including in the start cycle itself) is a protocol error.
            if (done_tick && state != S_WAIT && state != S_DONE) begin
                tb_fail <= 1'b1;
                state   <= S_DONE;
            end else begin
                case (state)
                    S_RST: begin
                        if (rst_cnt == RST_LAST) begin
                            reset <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            rst_cnt <= rst_cnt + RCW'(1);
                        end
                    end
                    S_IDLE: begin
                        bcd      <= op_bcd;
                        expected <= op_exp;
                        if (ready) begin
                            start <= 1'b1;
                            state <= S_ISSUE;
                        end
                    end
                    S_ISSUE: begin
                        wd    <= '0;
                        state <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (done_tick) begin
                            if (bin == expected) begin
                                test_cnt  <= test_cnt + 32'd1;
                                sweep_bcd <= bcd_inc(sweep_bcd);
                                sweep_bin <= sweep_bin + BIN_WIDTH'(1);
                                lfsr      <= lfsr_next;
                                if (test_cnt == TOTAL - 32'd1) begin
                                    tb_pass <= 1'b1;
                                    state   <= S_DONE;
                                end else begin
                                    state <= S_IDLE;
                                end
                            end else begin
                                tb_fail <= 1'b1;
                                state   <= S_DONE;
                            end
                        end else if (wd_next == 32'(TIMEOUT)) begin
                            tb_fail <= 1'b1;
                            state   <= S_DONE;
                        end else begin
                            wd <= wd_next;
                        end
                    end
                    S_DONE: begin
                    end
                    default: state <= S_RST;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bcd2bin_test_sweep.sv
// Bench for bcd2bin_test_sweep: two harness instances (decimal sweep and LFSR random) driven
// against a behavioural converter model with random latency, random ready stalls and faults.
`timescale 1ns/1ps
module tb_bcd2bin_test_sweep;

    localparam int          DIGITS       = 2;
    localparam int          BIN_WIDTH    = 7;
    localparam int          TIMEOUT      = 20;
    localparam int          RESET_CYCLES = 8;
    localparam int          LF_DIGITS    = 4;
    localparam int          LF_BIN_WIDTH = 14;
    localparam int          LF_TESTS     = 16;
    localparam logic [31:0] SEED         = 32'hACE1_2468;

    logic tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    logic [31:0] cyc = '0;
    always @(posedge tb_clk) cyc <= cyc + 32'd1;

    int n_checks = 0;
    int n_pass   = 0;

    // ---------------- sweep instance ----------------
    logic                  tb_rst_n     = 1'b0;
    logic                  tb_prog_done = 1'b1;
    logic                  pass, fail, dclk, dut_reset, start, ready, done_tick;
    logic [4*DIGITS-1:0]   bcd;
    logic [BIN_WIDTH-1:0]  bin;

    bcd2bin_test_sweep #(
        .DIGITS(DIGITS), .BIN_WIDTH(BIN_WIDTH), .MODE(0), .NUM_TESTS(64),
        .SEED(SEED), .TIMEOUT(TIMEOUT), .RESET_CYCLES(RESET_CYCLES)
    ) u_sweep (
        .tb_clk(tb_clk), .tb_rst_n(tb_rst_n), .tb_pass(pass), .tb_fail(fail),
        .tb_prog_done(tb_prog_done), .tb_verbosity(32'd2), .tb_cycle_cnt(cyc),
        .clk(dclk), .reset(dut_reset), .start(start), .bcd(bcd),
        .ready(ready), .done_tick(done_tick), .bin(bin)
    );

    // ---------------- LFSR instance ----------------
    logic                    lf_rst_n = 1'b0;
    logic                    lf_pass, lf_fail, lf_dclk, lf_reset, lf_start, lf_ready, lf_done;
    logic [4*LF_DIGITS-1:0]  lf_bcd;
    logic [LF_BIN_WIDTH-1:0] lf_bin = '0;

    bcd2bin_test_sweep #(
        .DIGITS(LF_DIGITS), .BIN_WIDTH(LF_BIN_WIDTH), .MODE(1), .NUM_TESTS(LF_TESTS),
        .SEED(SEED), .TIMEOUT(256), .RESET_CYCLES(8)
    ) u_lfsr (
        .tb_clk(tb_clk), .tb_rst_n(lf_rst_n), .tb_pass(lf_pass), .tb_fail(lf_fail),
        .tb_prog_done(1'b1), .tb_verbosity(32'd0), .tb_cycle_cnt(cyc),
        .clk(lf_dclk), .reset(lf_reset), .start(lf_start), .bcd(lf_bcd),
        .ready(lf_ready), .done_tick(lf_done), .bin(lf_bin)
    );

    function automatic int from_bcd(input logic [31:0] b, input int nd);
        int v;
        int p;
        v = 0;
        p = 1;
        for (int i = 0; i < nd; i++) begin
            v = v + int'(b[4*i +: 4]) * p;
            p = p * 10;
        end
        return v;
    endfunction

    function automatic logic [31:0] to_bcd(input int v, input int nd);
        logic [31:0] r;
        int          x;
        r = '0;
        x = v;
        for (int i = 0; i < nd; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [31:0] lfsr_step(input logic [31:0] x);
        return {x[30:0], x[31] ^ x[21] ^ x[1] ^ x[0]};
    endfunction

    // Converter model for the sweep instance: 0 correct, 1 bin[3] stuck at 0, 2 never answers.
    int                   fault_mode  = 0;
    logic                 ready_rand  = 1'b0;
    logic                 ready_block = 1'b0;
    logic                 spur_done   = 1'b0;
    logic                 gate        = 1'b1;
    logic                 m_busy = 1'b0, m_done = 1'b0;
    int                   m_lat  = 0;
    logic [4*DIGITS-1:0]  m_op   = '0;
    logic [BIN_WIDTH-1:0] m_bin  = '0;

    assign ready     = !m_busy && gate && !ready_block;
    assign done_tick = m_done | spur_done;
    assign bin       = m_bin;

    always @(posedge dclk) begin
        gate <= ready_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (dut_reset) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_lat  <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                if (m_lat == 0) begin
                    m_busy <= 1'b0;
                    if (fault_mode != 2) begin
                        m_done <= 1'b1;
                        m_bin  <= (fault_mode == 1) ? (BIN_WIDTH'(from_bcd(32'(m_op), DIGITS)) & 7'h77)
                                                    : BIN_WIDTH'(from_bcd(32'(m_op), DIGITS));
                    end
                end else begin
                    m_lat <= m_lat - 1;
                end
            end else if (start) begin
                m_busy <= 1'b1;
                m_op   <= bcd;
                m_lat  <= int'($urandom_range(1, 4));
            end
        end
    end

    // Always-correct converter model for the LFSR instance.
    logic                   lf_gate = 1'b1;
    logic                   lf_busy = 1'b0;
    int                     lf_lat  = 0;
    logic [4*LF_DIGITS-1:0] lf_op   = '0;

    assign lf_ready = !lf_busy && lf_gate;

    always @(posedge lf_dclk) begin
        lf_gate <= ($urandom_range(0, 2) != 0);
        if (lf_reset) begin
            lf_busy <= 1'b0;
            lf_done <= 1'b0;
            lf_lat  <= 0;
        end else begin
            lf_done <= 1'b0;
            if (lf_busy) begin
                if (lf_lat == 0) begin
                    lf_busy <= 1'b0;
                    lf_done <= 1'b1;
                    lf_bin  <= LF_BIN_WIDTH'(from_bcd(32'(lf_op), LF_DIGITS));
                end else begin
                    lf_lat <= lf_lat - 1;
                end
            end else if (lf_start) begin
                lf_busy <= 1'b1;
                lf_op   <= lf_bcd;
                lf_lat  <= int'($urandom_range(0, 6));
            end
        end
    end

    // Start/done logs sampled on the falling edge.
    int                     st_cyc[$];
    logic [4*DIGITS-1:0]    st_bcd[$];
    int                     dn_cyc[$];
    int                     double_start = 0;
    logic                   start_d = 1'b0;
    logic [4*LF_DIGITS-1:0] lf_st_bcd[$];
    int                     lf_double = 0;
    logic                   lf_start_d = 1'b0;

    always @(negedge tb_clk) begin
        if (start === 1'b1) begin
            st_cyc.push_back(int'(cyc));
            st_bcd.push_back(bcd);
            if (start_d) double_start++;
        end
        if (done_tick === 1'b1) dn_cyc.push_back(int'(cyc));
        start_d = (start === 1'b1);
        if (lf_start === 1'b1) begin
            lf_st_bcd.push_back(lf_bcd);
            if (lf_start_d) lf_double++;
        end
        lf_start_d = (lf_start === 1'b1);
    end

    task automatic step();
        @(negedge tb_clk);
        #1;
    endtask

    task automatic run_reset();
        step();
        tb_rst_n     = 1'b0;
        tb_prog_done = 1'b1;
        step();
        st_cyc.delete();
        st_bcd.delete();
        dn_cyc.delete();
        double_start = 0;
        tb_rst_n     = 1'b1;
    endtask

    task automatic wait_end(input int budget, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < budget; i++) begin
            step();
            if (pass === 1'b1 || fail === 1'b1) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [11:0] obs;
        step();
        tb_rst_n     = 1'b0;
        tb_prog_done = 1'b1;
        #1;
        obs = {dut_reset, start, bcd, pass, fail};
        n_checks++;
        if (obs !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) $display("FAIL reset_values: got %h want %h", obs, {1'b1, 1'b0, 8'h00, 1'b0, 1'b0});
        else n_pass++;

        tb_prog_done = 1'b0;
        tb_rst_n     = 1'b1;
        repeat (4) step();
        n_checks++;
        if (dut_reset !== 1'b1) $display("FAIL prog_done_hold: reset=%b want 1", dut_reset);
        else n_pass++;

        // Edge E1 is the first with both resets released; reset falls on edge E(RESET_CYCLES+2).
        tb_prog_done = 1'b1;
        repeat (RESET_CYCLES + 1) step();
        n_checks++;
        if (dut_reset !== 1'b1) $display("FAIL reset_hold: reset=%b want 1 after %0d edges", dut_reset, RESET_CYCLES + 1);
        else n_pass++;
        step();
        n_checks++;
        if (dut_reset !== 1'b0) $display("FAIL reset_release: reset=%b want 0 after %0d edges", dut_reset, RESET_CYCLES + 2);
        else n_pass++;
    endtask

    task automatic test_sweep();
        bit to;
        int bad;
        fault_mode = 0;
        ready_rand = 1'b0;
        run_reset();
        wait_end(5000, to);
        n_checks++;
        if (to !== 1'b0) $display("FAIL sweep_timeout: no pass/fail within budget");
        else n_pass++;
        n_checks++;
        if ({pass, fail} !== 2'b10) $display("FAIL sweep_result: pass=%b fail=%b want 1/0", pass, fail);
        else n_pass++;
        n_checks++;
        if (st_cyc.size() !== 100) $display("FAIL sweep_starts: got %0d want 100", st_cyc.size());
        else n_pass++;

        bad = 0;
        for (int k = 0; k < st_bcd.size(); k++)
            if (32'(st_bcd[k]) !== to_bcd(k, DIGITS)) bad++;
        n_checks++;
        if (bad !== 0 || st_bcd.size() == 0) $display("FAIL sweep_operands: %0d operands out of decimal order", bad);
        else n_pass++;
        n_checks++;
        if (st_bcd.size() == 0 || st_bcd[st_bcd.size() - 1] !== 8'h99) $display("FAIL sweep_last: last operand wrong, want 99");
        else n_pass++;
        n_checks++;
        if (double_start !== 0) $display("FAIL sweep_start_width: %0d multi-cycle start pulses, want 0", double_start);
        else n_pass++;

        // Start-to-start spacing never exceeds converter latency plus three cycles.
        bad = 0;
        for (int k = 0; k + 1 < st_cyc.size(); k++) begin
            if (k >= dn_cyc.size()) bad++;
            else if (st_cyc[k + 1] - st_cyc[k] > (dn_cyc[k] - st_cyc[k]) + 3) bad++;
        end
        n_checks++;
        if (bad !== 0) $display("FAIL sweep_throughput: %0d slow tests, want 0", bad);
        else n_pass++;

        repeat (20) step();
        n_checks++;
        if (st_cyc.size() !== 100 || pass !== 1'b1) $display("FAIL sweep_done_hold: starts=%0d pass=%b want 100/1", st_cyc.size(), pass);
        else n_pass++;
    endtask

    task automatic test_stuck_bit();
        bit to;
        fault_mode = 1;
        ready_rand = 1'b1;
        run_reset();
        wait_end(2000, to);
        n_checks++;
        if (to !== 1'b0 || {pass, fail} !== 2'b01) $display("FAIL stuck_result: timeout=%b pass=%b fail=%b want 0/0/1", to, pass, fail);
        else n_pass++;
        n_checks++;
        if (st_bcd.size() !== 9 || st_bcd[st_bcd.size() - 1] !== 8'h08) $display("FAIL stuck_operand: starts=%0d want 9 ending at operand 08", st_bcd.size());
        else n_pass++;
        repeat (30) step();
        n_checks++;
        if (st_bcd.size() !== 9 || fail !== 1'b1 || pass !== 1'b0) $display("FAIL stuck_hold: starts=%0d fail=%b pass=%b want 9/1/0", st_bcd.size(), fail, pass);
        else n_pass++;
        fault_mode = 0;
        ready_rand = 1'b0;
    endtask

    task automatic test_timeout();
        int  c0;
        int  cf;
        fault_mode = 2;
        ready_rand = 1'b0;
        run_reset();
        for (int i = 0; i < 100 && st_cyc.size() == 0; i++) step();
        c0 = (st_cyc.size() != 0) ? st_cyc[0] : -1000;
        cf = -1;
        for (int i = 0; i < 100; i++) begin
            if (fail === 1'b1) begin
                cf = int'(cyc);
                break;
            end
            step();
        end
        // tb_fail registers TIMEOUT cycles after the start pulse ends.
        n_checks++;
        if (cf - c0 !== TIMEOUT + 1) $display("FAIL timeout_latency: fail seen %0d cycles after start seen, want %0d", cf - c0, TIMEOUT + 1);
        else n_pass++;
        repeat (10) step();
        n_checks++;
        if (st_cyc.size() !== 1 || pass !== 1'b0) $display("FAIL timeout_hold: starts=%0d pass=%b want 1/0", st_cyc.size(), pass);
        else n_pass++;
        fault_mode = 0;
    endtask

    task automatic test_spurious();
        ready_block = 1'b1;
        run_reset();
        for (int i = 0; i < 40 && dut_reset !== 1'b0; i++) step();
        n_checks++;
        if (dut_reset !== 1'b0) $display("FAIL spur_setup: reset=%b want 0", dut_reset);
        else n_pass++;
        spur_done = 1'b1;
        n_checks++;
        if (fail !== 1'b0) $display("FAIL spur_early: fail=%b want 0 before edge", fail);
        else n_pass++;
        step();
        spur_done = 1'b0;
        n_checks++;
        if ({pass, fail} !== 2'b01 || st_cyc.size() !== 0) $display("FAIL spur_detect: pass=%b fail=%b starts=%0d want 0/1/0", pass, fail, st_cyc.size());
        else n_pass++;
        ready_block = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        bit          to;
        int          bad;
        logic [11:0] obs;
        fault_mode = 0;
        ready_rand = 1'b1;
        run_reset();
        for (int i = 0; i < 500 && st_cyc.size() < 5; i++) step();
        step();
        tb_rst_n = 1'b0;
        #1;
        obs = {dut_reset, start, bcd, pass, fail};
        n_checks++;
        if (st_cyc.size() !== 5 || obs !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) $display("FAIL midrun_reset: starts=%0d outputs=%h want 5/%h", st_cyc.size(), obs, {1'b1, 1'b0, 8'h00, 1'b0, 1'b0});
        else n_pass++;
        #1;
        tb_rst_n = 1'b1;
        st_cyc.delete();
        st_bcd.delete();
        dn_cyc.delete();
        double_start = 0;
        wait_end(5000, to);
        n_checks++;
        if (to !== 1'b0 || {pass, fail} !== 2'b10) $display("FAIL midrun_result: timeout=%b pass=%b fail=%b want 0/1/0", to, pass, fail);
        else n_pass++;
        bad = 0;
        for (int k = 0; k < st_bcd.size(); k++)
            if (32'(st_bcd[k]) !== to_bcd(k, DIGITS)) bad++;
        n_checks++;
        if (st_bcd.size() !== 100 || bad !== 0) $display("FAIL midrun_restart: starts=%0d misordered=%0d want 100/0", st_bcd.size(), bad);
        else n_pass++;
        ready_rand = 1'b0;
    endtask

    task automatic test_lfsr();
        logic [31:0]            lf;
        logic [4*LF_DIGITS-1:0] exp_op;
        logic [4*LF_DIGITS-1:0] got;
        int                     bad_seq;
        int                     bad_dig;
        bit                     to;
        lf_rst_n = 1'b1;
        to = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            step();
            if (lf_pass === 1'b1 || lf_fail === 1'b1) begin
                to = 1'b0;
                break;
            end
        end
        n_checks++;
        if (to !== 1'b0 || {lf_pass, lf_fail} !== 2'b10) $display("FAIL lfsr_result: timeout=%b pass=%b fail=%b want 0/1/0", to, lf_pass, lf_fail);
        else n_pass++;
        n_checks++;
        if (lf_st_bcd.size() !== LF_TESTS || lf_double !== 0) $display("FAIL lfsr_starts: got %0d (wide %0d) want %0d (0)", lf_st_bcd.size(), lf_double, LF_TESTS);
        else n_pass++;
        lf      = SEED;
        bad_seq = 0;
        bad_dig = 0;
        for (int k = 0; k < lf_st_bcd.size(); k++) begin
            got = lf_st_bcd[k];
            for (int i = 0; i < LF_DIGITS; i++) begin
                exp_op[4*i +: 4] = 4'(lf[4*i +: 4] % 10);
                if (got[4*i +: 4] > 4'd9) bad_dig++;
            end
            if (got !== exp_op) bad_seq++;
            lf = lfsr_step(lf);
        end
        n_checks++;
        if (bad_dig !== 0) $display("FAIL lfsr_digits: %0d digits above 9, want 0", bad_dig);
        else n_pass++;
        n_checks++;
        if (bad_seq !== 0) $display("FAIL lfsr_operands: %0d operands off the LFSR sequence, want 0", bad_seq);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_stuck_bit();
        test_timeout();
        test_spurious();
        test_reset_mid_run();
        test_lfsr();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
